// File: rtl/persiana_motor_model_if.sv
// Command/sensor bundle between the blind controller (master) and the motor plant (slave).
interface persiana_motor_model_if;
   logic       subir;
   logic       bajar;
   logic       Sinf;
   logic       Smed;
   logic       Ssup;
   logic [7:0] posicion;
   logic       moviendo;
   logic       fallo;
   logic [2:0] estado;

   modport master (
      output subir, bajar,
      input  Sinf, Smed, Ssup, posicion, moviendo, fallo, estado
   );

   modport slave (
      input  subir, bajar,
      output Sinf, Smed, Ssup, posicion, moviendo, fallo, estado
   );
endinterface

// File: rtl/persiana_motor_model.sv
// Blind motor plant: position counter moved on a prescaled tick, reversal dead time,
// fault lock on contradictory commands, and registered limit/mid sensors.
module persiana_motor_model #(
   parameter int TICK_DIV   = 1000,
   parameter int POS_MAX    = 200,
   parameter int POS_MID    = 100,
   parameter int MID_WIN    = 2,
   parameter int DEAD_TICKS = 3
) (
   input  logic                    clk,
   input  logic                    reseteo,
   persiana_motor_model_if.slave   bus
);

   typedef enum logic [2:0] {
      REPOSO   = 3'd0,
      SUBIENDO = 3'd1,
      BAJANDO  = 3'd2,
      MUERTO   = 3'd3,
      FALLO    = 3'd4
   } estado_t;

   localparam int CW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEAD_TICKS + 1);

   localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEAD_END = DW'(DEAD_TICKS);
   localparam logic [7:0]    POS_TOP  = 8'(POS_MAX);
   localparam logic [7:0]    POS_PEN  = 8'(POS_MAX - 1);

   localparam int WIN_LO_I = (POS_MID > MID_WIN) ? (POS_MID - MID_WIN) : 0;
   localparam int WIN_HI_I = ((POS_MID + MID_WIN) > 255) ? 255 : (POS_MID + MID_WIN);
   localparam logic [7:0] WIN_LO = 8'(WIN_LO_I);
   localparam logic [7:0] WIN_HI = 8'(WIN_HI_I);

   // Mid-window test done on closed bounds so no signed subtraction is needed.
   function automatic logic en_ventana(input logic [7:0] p);
      return (p >= WIN_LO) && (p <= WIN_HI);
   endfunction

   // One position step, saturated to 0..POS_MAX.
   function automatic logic [7:0] paso_saturado(input logic [7:0] p, input logic arriba);
      logic [7:0] r;
      r = p;
      if (arriba) begin
         if (p < POS_TOP) r = p + 8'd1;
      end else begin
         if (p != 8'd0) r = p - 8'd1;
      end
      return r;
   endfunction

   logic subir_p0, subir_p1;
   logic bajar_p0, bajar_p1;
   logic s_up, s_dn;

   logic [CW-1:0] presc;
   logic          tick;

   estado_t       estado_q, estado_d;
   logic [7:0]    pos_q, pos_d;
   logic [DW-1:0] dead_q, dead_d, dead_inc;

   logic sinf_q, smed_q, ssup_q;

   // Stage p0/p1: two-flop synchroniser for the asynchronous commands
   always_ff @(posedge clk or posedge reseteo) begin
      if (reseteo) begin
         subir_p0 <= 1'b0;
         subir_p1 <= 1'b0;
         bajar_p0 <= 1'b0;
         bajar_p1 <= 1'b0;
      end else begin
         subir_p0 <= bus.subir;
         subir_p1 <= subir_p0;
         bajar_p0 <= bus.bajar;
         bajar_p1 <= bajar_p0;
      end
   end

   assign s_up = subir_p1;
   assign s_dn = bajar_p1;

   assign tick = (presc == DIV_LAST);

   always_ff @(posedge clk or posedge reseteo) begin
      if (reseteo) presc <= '0;
      else         presc <= tick ? '0 : presc + 1'b1;
   end

   assign dead_inc = dead_q + 1'b1;

   always_comb begin
      estado_d = estado_q;
      pos_d    = pos_q;
      dead_d   = dead_q;
      case (estado_q)
         REPOSO: begin
            if (s_up && s_dn)                 estado_d = FALLO;
            else if (s_up && (pos_q < POS_TOP)) estado_d = SUBIENDO;
            else if (s_dn && (pos_q != 8'd0))   estado_d = BAJANDO;
         end
         SUBIENDO: begin
            if (s_up && s_dn) begin
               estado_d = FALLO;
            end else if (s_dn) begin
               estado_d = MUERTO;
               dead_d   = '0;
            end else if (!s_up) begin
               estado_d = REPOSO;
            end else if (tick) begin
               pos_d = paso_saturado(pos_q, 1'b1);
               if (pos_q >= POS_PEN) estado_d = REPOSO;
            end
         end
         BAJANDO: begin
            if (s_up && s_dn) begin
               estado_d = FALLO;
            end else if (s_up) begin
               estado_d = MUERTO;
               dead_d   = '0;
            end else if (!s_dn) begin
               estado_d = REPOSO;
            end else if (tick) begin
               pos_d = paso_saturado(pos_q, 1'b0);
               if (pos_q <= 8'd1) estado_d = REPOSO;
            end
         end
         MUERTO: begin
            if (s_up && s_dn) begin
               estado_d = FALLO;
            end else if (tick) begin
               dead_d = dead_inc;
               if (dead_inc == DEAD_END) estado_d = REPOSO;
            end
         end
         FALLO: begin
            if (tick && !s_up && !s_dn) estado_d = REPOSO;
         end
         default: estado_d = REPOSO;
      endcase
   end

   // Stage p2: state, position and dead-time registers
   always_ff @(posedge clk or posedge reseteo) begin
      if (reseteo) begin
         estado_q <= REPOSO;
         pos_q    <= '0;
         dead_q   <= '0;
      end else begin
         estado_q <= estado_d;
         pos_q    <= pos_d;
         dead_q   <= dead_d;
      end
   end

   // Stage p3: sensors lag the position register by one clock
   always_ff @(posedge clk or posedge reseteo) begin
      if (reseteo) begin
         sinf_q <= 1'b1;
         smed_q <= 1'b0;
         ssup_q <= 1'b0;
      end else begin
         sinf_q <= (pos_q == 8'd0);
         smed_q <= en_ventana(pos_q);
         ssup_q <= (pos_q == POS_TOP);
      end
   end

   assign bus.Sinf     = sinf_q;
   assign bus.Smed     = smed_q;
   assign bus.Ssup     = ssup_q;
   assign bus.posicion = pos_q;
   assign bus.estado   = estado_q;
   assign bus.moviendo = (estado_q == SUBIENDO) || (estado_q == BAJANDO);
   assign bus.fallo    = (estado_q == FALLO);

endmodule

// File: tb/tb_persiana_motor_model.sv
// Randomised and directed bench for the blind motor plant against a behavioural model.
module tb_persiana_motor_model;
   localparam int TD   = 4;
   localparam int PM   = 16;
   localparam int PMID = 8;
   localparam int MW   = 1;
   localparam int DT   = 2;

   logic clk = 1'b0;
   logic reseteo;
   always #5 clk = ~clk;

   persiana_motor_model_if bus ();

   persiana_motor_model #(
      .TICK_DIV(TD), .POS_MAX(PM), .POS_MID(PMID), .MID_WIN(MW), .DEAD_TICKS(DT)
   ) dut (
      .clk     (clk),
      .reseteo (reseteo),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural plant: direction, remaining dead ticks and a fault flag.
   int m_pos, m_pos_prev, m_dir, m_dead_left, m_edges;
   bit m_fault;
   bit up0, up1, dn0, dn1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int m_estado();
      if (m_fault)          return 4;
      if (m_dead_left > 0)  return 3;
      if (m_dir > 0)        return 1;
      if (m_dir < 0)        return 2;
      return 0;
   endfunction

   task automatic model_reset();
      m_pos = 0; m_pos_prev = 0; m_dir = 0; m_dead_left = 0; m_edges = 0;
      m_fault = 0; up0 = 0; up1 = 0; dn0 = 0; dn1 = 0;
   endtask

   task automatic model_step(input bit up_in, input bit dn_in);
      bit up, dn, tick;
      int want;
      up = up1; dn = dn1;
      tick = ((m_edges % TD) == TD - 1);
      m_edges++;
      m_pos_prev = m_pos;
      if (m_fault) begin
         if (tick && !up && !dn) m_fault = 0;
      end else if (up && dn) begin
         m_fault = 1; m_dir = 0; m_dead_left = 0;
      end else if (m_dead_left > 0) begin
         if (tick) m_dead_left--;
      end else if (m_dir == 0) begin
         if (up && m_pos < PM)     m_dir = 1;
         else if (dn && m_pos > 0) m_dir = -1;
      end else begin
         want = up ? 1 : (dn ? -1 : 0);
         if (want == 0) m_dir = 0;
         else if (want != m_dir) begin
            m_dir = 0; m_dead_left = DT;
         end else if (tick) begin
            m_pos += m_dir;
            if (m_pos == 0 || m_pos == PM) m_dir = 0;
         end
      end
      up1 = up0; up0 = up_in;
      dn1 = dn0; dn0 = dn_in;
   endtask

   task automatic compare_all();
      int d;
      d = m_pos_prev - PMID;
      if (d < 0) d = -d;
      check_val("estado",   bus.estado,   m_estado());
      check_val("posicion", bus.posicion, m_pos);
      check_val("Sinf",     bus.Sinf,     m_pos_prev == 0);
      check_val("Ssup",     bus.Ssup,     m_pos_prev == PM);
      check_val("Smed",     bus.Smed,     d <= MW);
      check_val("moviendo", bus.moviendo, m_dir != 0);
      check_val("fallo",    bus.fallo,    m_fault);
   endtask

   task automatic cyc(input bit up, input bit dn);
      bus.subir = up;
      bus.bajar = dn;
      @(posedge clk);
      model_step(up, dn);
      @(negedge clk);
      compare_all();
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_est"},  bus.estado,   0);
      check_val({tag, "_pos"},  bus.posicion, 0);
      check_val({tag, "_Sinf"}, bus.Sinf,     1);
      check_val({tag, "_Smed"}, bus.Smed,     0);
      check_val({tag, "_Ssup"}, bus.Ssup,     0);
      check_val({tag, "_mov"},  bus.moviendo, 0);
      check_val({tag, "_fal"},  bus.fallo,    0);
   endtask

   task automatic do_reset();
      bus.subir = 0; bus.bajar = 0;
      reseteo = 1'b1;
      repeat (2) @(negedge clk);
      reseteo = 1'b0;
      model_reset();
      check_reset_vals("rst");
   endtask

   task automatic lower_to_zero();
      for (int i = 0; i < 200 && !(m_pos == 0 && m_estado() == 0); i++) cyc(0, 1);
      cyc(0, 0);
      check_val("lower_pos", bus.posicion, 0);
   endtask

   task automatic raise_to(input int p);
      for (int i = 0; i < 200 && m_pos != p; i++) cyc(1, 0);
      check_val("raise_pos", bus.posicion, p);
   endtask

   initial begin
      bit saw_muerto;
      int cmd, len;
      bus.subir = 0; bus.bajar = 0;
      reseteo = 1'b1;
      @(negedge clk);
      do_reset();

      // Raise: estado follows subir after three clocks
      cyc(1, 0); cyc(1, 0);
      check_val("est_2clk", bus.estado, 0);
      cyc(1, 0);
      check_val("est_3clk", bus.estado, 1);
      for (int i = 0; i < 200 && !(m_pos == PM && m_estado() == 0); i++) cyc(1, 0);
      cyc(1, 0);
      check_val("top_pos",  bus.posicion, PM);
      check_val("top_Ssup", bus.Ssup, 1);
      check_val("top_est",  bus.estado, 0);

      // Lower by five ticks
      for (int i = 0; i < 200 && m_pos != PM - 5; i++) cyc(0, 1);
      repeat (6) cyc(0, 0);
      check_val("low5_pos",  bus.posicion, PM - 5);
      check_val("low5_est",  bus.estado, 0);
      check_val("low5_Ssup", bus.Ssup, 0);

      // Reversal at position 5
      lower_to_zero();
      raise_to(5);
      saw_muerto = 0;
      for (int i = 0; i < 200 && !(m_pos == 0 && m_estado() == 0); i++) begin
         cyc(0, 1);
         if (bus.estado == 3) begin
            saw_muerto = 1;
            check_val("dead_pos", bus.posicion, 5);
         end
      end
      cyc(0, 0);
      check_val("saw_muerto", saw_muerto, 1);
      check_val("rev_Sinf",   bus.Sinf, 1);

      // Contradictory commands lock into FALLO
      raise_to(3);
      repeat (4) cyc(1, 1);
      check_val("flt_est", bus.estado, 4);
      check_val("flt_fal", bus.fallo, 1);
      check_val("flt_pos", bus.posicion, 3);
      repeat (8) cyc(0, 0);
      check_val("flt_exit", bus.estado, 0);

      // Random command segments
      for (int s = 0; s < 60; s++) begin
         cmd = $urandom_range(0, 9);
         len = $urandom_range(1, 40);
         for (int k = 0; k < len; k++) begin
            if (cmd < 4)       cyc(1, 0);
            else if (cmd < 8)  cyc(0, 1);
            else if (cmd == 8) cyc(0, 0);
            else               cyc(1, 1);
         end
      end

      // Asynchronous reset mid-raise
      repeat (8) cyc(0, 0);
      lower_to_zero();
      raise_to(6);
      check_val("pre_rst_est", bus.estado, 1);
      #2;
      reseteo = 1'b1;
      bus.subir = 0;
      #1;
      check_reset_vals("arst");
      @(negedge clk);
      reseteo = 1'b0;
      model_reset();
      repeat (10) cyc(1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
